// File: rtl/irq_ctrl.sv
// irq_ctrl: flag/enable interrupt controller with fixed-priority vectoring.
// Define IRQ_EDGE_DETECT_EN to turn irq_in into rising-edge triggered requests.
module irq_ctrl #(
    parameter int unsigned NUM_IRQ    = 5,
    parameter logic [15:0] IF_ADDR    = 16'hFF0F,
    parameter logic [15:0] IE_ADDR    = 16'hFFFF,
    parameter logic [7:0]  VEC_BASE   = 8'h40,
    parameter logic [7:0]  VEC_STRIDE = 8'h08
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        a,
    input  logic [7:0]         din,
    output logic [7:0]         dout,
    input  logic               rd,
    input  logic               wr,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               int_req,
    output logic [7:0]         int_vec,
    input  logic               int_ack
);

    logic [NUM_IRQ-1:0] if_q;
    logic [NUM_IRQ-1:0] if_d;
    logic [NUM_IRQ-1:0] ie_q;
    logic [NUM_IRQ-1:0] ie_d;
    logic [NUM_IRQ-1:0] ev;
    logic [NUM_IRQ-1:0] pend;
    logic [NUM_IRQ-1:0] ack_mask;
    logic [2:0]         act_k;
    logic               sel_if;
    logic               sel_ie;
    logic               wr_if;
    logic               wr_ie;
    logic               ack_ok;
    logic [7:0]         if_rd;
    logic [7:0]         ie_rd;

    // dout does not depend on the read strobe; din may be wider than the channel count
    logic [8:0]         unused_bits;
    assign unused_bits = {rd, din};

    assign sel_if = (a == IF_ADDR);
    assign sel_ie = (a == IE_ADDR);
    assign wr_if  = wr && sel_if;
    assign wr_ie  = wr && sel_ie;

`ifdef IRQ_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] irq_q;

    // request history; all-ones so a line already high at reset exit is not an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= '1;
        end else begin
            irq_q <= irq_in;
        end
    end

    assign ev = irq_in & ~irq_q;
`else
    assign ev = irq_in;
`endif

    assign pend    = if_q & ie_q;
    assign int_req = |pend;

    // lowest-index pending channel wins
    always_comb begin
        act_k = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                act_k = 3'(i);
            end
        end
    end

    assign int_vec = VEC_BASE + VEC_STRIDE * {5'd0, act_k};

    // a CPU write to IF takes precedence, so the ack is dropped then
    assign ack_ok = int_ack && int_req && !wr_if;

    // one-hot clear mask for the channel being acknowledged
    always_comb begin
        ack_mask = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            ack_mask[i] = ack_ok && (act_k == 3'(i));
        end
    end

    // flag next state: new request events always win over write data and ack
    always_comb begin
        if_d = (if_q & ~ack_mask) | ev;
        if (wr_if) begin
            if_d = din[NUM_IRQ-1:0] | ev;
        end
    end

    // enable next state
    always_comb begin
        ie_d = ie_q;
        if (wr_ie) begin
            ie_d = din[NUM_IRQ-1:0];
        end
    end

    // flag and enable registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_q <= '0;
            ie_q <= '0;
        end else begin
            if_q <= if_d;
            ie_q <= ie_d;
        end
    end

    // read views: unimplemented IF bits read 1, unimplemented IE bits read 0
    always_comb begin
        if_rd = '1;
        ie_rd = '0;
        if_rd[NUM_IRQ-1:0] = if_q;
        ie_rd[NUM_IRQ-1:0] = ie_q;
    end

    // combinational read mux
    always_comb begin
        dout = 8'hFF;
        unique case (1'b1)
            sel_if:  dout = if_rd;
            sel_ie:  dout = ie_rd;
            default: dout = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scoreboard bench for irq_ctrl with default parameters.
// Covers pulse/ack, priority walk, collisions, held inputs and async reset.
module tb_irq_ctrl;

    localparam logic [15:0] IF_A = 16'hFF0F;
    localparam logic [15:0] IE_A = 16'hFFFF;
    localparam logic [15:0] NO_A = 16'h1234;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        rd;
    logic        wr;
    logic [4:0]  irq_in;
    logic        int_req;
    logic [7:0]  int_vec;
    logic        int_ack;

    typedef struct {
        logic       req;
        logic [7:0] vec;
        logic [7:0] flag;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;

    irq_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .din     (din),
        .dout    (dout),
        .rd      (rd),
        .wr      (wr),
        .irq_in  (irq_in),
        .int_req (int_req),
        .int_vec (int_vec),
        .int_ack (int_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [15:0] addr, input logic [7:0] data);
        a   = addr;
        din = data;
        wr  = 1'b1;
        tick();
        wr  = 1'b0;
        a   = NO_A;
        din = 8'h00;
    endtask

    task automatic pulse(input logic [4:0] m);
        irq_in = m;
        tick();
        irq_in = 5'h00;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        #3;
        exp_q.push_back('{1'b0, 8'h40, 8'hE0});
        e = exp_q.pop_front();
        a = IF_A; rd = 1'b1; #1;
        n_cmp += 3;
        if (int_req !== e.req) begin n_bad++; $display("FAIL reset_req got %b want %b", int_req, e.req); end
        if (int_vec !== e.vec) begin n_bad++; $display("FAIL reset_vec got %h want %h", int_vec, e.vec); end
        if (dout !== e.flag) begin n_bad++; $display("FAIL reset_if got %h want %h", dout, e.flag); end
        a = NO_A; #1;
        n_cmp++;
        if (dout !== 8'hFF) begin n_bad++; $display("FAIL reset_unsel got %h want ff", dout); end
        rd = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_pulse();
        exp_t e;
        wr_reg(IE_A, 8'h04);
        tick();
        pulse(5'h04);
        exp_q.push_back('{1'b1, 8'h50, 8'hE4});
        e = exp_q.pop_front();
        a = IF_A; rd = 1'b1; #1;
        n_cmp += 3;
        if (int_req !== e.req) begin n_bad++; $display("FAIL pulse_req got %b want %b", int_req, e.req); end
        if (int_vec !== e.vec) begin n_bad++; $display("FAIL pulse_vec got %h want %h", int_vec, e.vec); end
        if (dout !== e.flag) begin n_bad++; $display("FAIL pulse_if got %h want %h", dout, e.flag); end
        rd = 1'b0;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        exp_q.push_back('{1'b0, 8'h40, 8'hE0});
        e = exp_q.pop_front();
        rd = 1'b1; #1;
        n_cmp += 3;
        if (int_req !== e.req) begin n_bad++; $display("FAIL pulse_ack_req got %b want %b", int_req, e.req); end
        if (int_vec !== e.vec) begin n_bad++; $display("FAIL pulse_ack_vec got %h want %h", int_vec, e.vec); end
        if (dout !== e.flag) begin n_bad++; $display("FAIL pulse_ack_if got %h want %h", dout, e.flag); end
        rd = 1'b0;
    endtask

    task automatic test_priority();
        exp_t e;
        wr_reg(IF_A, 8'h1F);
        wr_reg(IE_A, 8'h1A);
        exp_q.push_back('{1'b1, 8'h48, 8'hFF});
        exp_q.push_back('{1'b1, 8'h58, 8'hFD});
        exp_q.push_back('{1'b1, 8'h60, 8'hF5});
        exp_q.push_back('{1'b0, 8'h40, 8'hE5});
        exp_q.push_back('{1'b0, 8'h40, 8'hE5});
        for (int s = 0; s < 5; s++) begin
            e = exp_q.pop_front();
            a = IF_A; rd = 1'b1; #1;
            n_cmp += 3;
            if (int_req !== e.req) begin n_bad++; $display("FAIL prio%0d_req got %b want %b", s, int_req, e.req); end
            if (int_vec !== e.vec) begin n_bad++; $display("FAIL prio%0d_vec got %h want %h", s, int_vec, e.vec); end
            if (dout !== e.flag) begin n_bad++; $display("FAIL prio%0d_if got %h want %h", s, dout, e.flag); end
            rd = 1'b0;
            int_ack = 1'b1;
            tick();
            int_ack = 1'b0;
        end
    endtask

    task automatic test_ack_collision();
        exp_t e;
        wr_reg(IF_A, 8'h00);
        wr_reg(IE_A, 8'h02);
        pulse(5'h02);
        tick();
        exp_q.push_back('{1'b1, 8'h48, 8'hE2});
        e = exp_q.pop_front();
        a = IF_A; rd = 1'b1; #1;
        n_cmp += 3;
        if (int_req !== e.req) begin n_bad++; $display("FAIL coll_pre_req got %b want %b", int_req, e.req); end
        if (int_vec !== e.vec) begin n_bad++; $display("FAIL coll_pre_vec got %h want %h", int_vec, e.vec); end
        if (dout !== e.flag) begin n_bad++; $display("FAIL coll_pre_if got %h want %h", dout, e.flag); end
        rd = 1'b0;
        int_ack = 1'b1;
        irq_in  = 5'h02;
        tick();
        int_ack = 1'b0;
        irq_in  = 5'h00;
        exp_q.push_back('{1'b1, 8'h48, 8'hE2});
        e = exp_q.pop_front();
        rd = 1'b1; #1;
        n_cmp += 3;
        if (int_req !== e.req) begin n_bad++; $display("FAIL coll_req got %b want %b", int_req, e.req); end
        if (int_vec !== e.vec) begin n_bad++; $display("FAIL coll_vec got %h want %h", int_vec, e.vec); end
        if (dout !== e.flag) begin n_bad++; $display("FAIL coll_if got %h want %h", dout, e.flag); end
        rd = 1'b0;
    endtask

    task automatic test_write_priority();
        exp_t e;
        wr_reg(IE_A, 8'h1F);
        a       = IF_A;
        din     = 8'h00;
        wr      = 1'b1;
        irq_in  = 5'h01;
        int_ack = 1'b1;
        tick();
        wr      = 1'b0;
        irq_in  = 5'h00;
        int_ack = 1'b0;
        exp_q.push_back('{1'b1, 8'h40, 8'hE1});
        e = exp_q.pop_front();
        a = IF_A; rd = 1'b1; #1;
        n_cmp += 3;
        if (int_req !== e.req) begin n_bad++; $display("FAIL wrprio_req got %b want %b", int_req, e.req); end
        if (int_vec !== e.vec) begin n_bad++; $display("FAIL wrprio_vec got %h want %h", int_vec, e.vec); end
        if (dout !== e.flag) begin n_bad++; $display("FAIL wrprio_if got %h want %h", dout, e.flag); end
        a = IE_A; #1;
        n_cmp++;
        if (dout !== 8'h1F) begin n_bad++; $display("FAIL ie_read got %h want 1f", dout); end
        rd = 1'b0;
        a  = NO_A;
    endtask

    task automatic test_held();
        exp_t e;
        exp_t held;
`ifdef IRQ_EDGE_DETECT_EN
        held = '{1'b0, 8'h40, 8'hE0};
`else
        held = '{1'b1, 8'h58, 8'hE8};
`endif
        wr_reg(IF_A, 8'h00);
        wr_reg(IE_A, 8'h08);
        irq_in = 5'h08;
        repeat (10) tick();
        exp_q.push_back('{1'b1, 8'h58, 8'hE8});
        e = exp_q.pop_front();
        a = IF_A; rd = 1'b1; #1;
        n_cmp += 3;
        if (int_req !== e.req) begin n_bad++; $display("FAIL held_req got %b want %b", int_req, e.req); end
        if (int_vec !== e.vec) begin n_bad++; $display("FAIL held_vec got %h want %h", int_vec, e.vec); end
        if (dout !== e.flag) begin n_bad++; $display("FAIL held_if got %h want %h", dout, e.flag); end
        rd = 1'b0;
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        exp_q.push_back(held);
        tick();
        tick();
        exp_q.push_back(held);
        irq_in = 5'h00;
        tick();
        exp_q.push_back(held);
        for (int s = 0; s < 3; s++) begin
            e = exp_q.pop_front();
            a = IF_A; rd = 1'b1; #1;
            n_cmp += 2;
            if (int_req !== e.req) begin n_bad++; $display("FAIL held_ack%0d_req got %b want %b", s, int_req, e.req); end
            if (dout !== e.flag) begin n_bad++; $display("FAIL held_ack%0d_if got %h want %h", s, dout, e.flag); end
            rd = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        wr_reg(IF_A, 8'h1F);
        wr_reg(IE_A, 8'h1F);
        exp_q.push_back('{1'b1, 8'h40, 8'hFF});
        e = exp_q.pop_front();
        a = IF_A; rd = 1'b1; #1;
        n_cmp += 3;
        if (int_req !== e.req) begin n_bad++; $display("FAIL rmid_pre_req got %b want %b", int_req, e.req); end
        if (int_vec !== e.vec) begin n_bad++; $display("FAIL rmid_pre_vec got %h want %h", int_vec, e.vec); end
        if (dout !== e.flag) begin n_bad++; $display("FAIL rmid_pre_if got %h want %h", dout, e.flag); end
        int_ack = 1'b1;
        #1;
        rst = 1'b0;
        exp_q.push_back('{1'b0, 8'h40, 8'hE0});
        #1;
        e = exp_q.pop_front();
        n_cmp += 3;
        if (int_req !== e.req) begin n_bad++; $display("FAIL rmid_req got %b want %b", int_req, e.req); end
        if (int_vec !== e.vec) begin n_bad++; $display("FAIL rmid_vec got %h want %h", int_vec, e.vec); end
        if (dout !== e.flag) begin n_bad++; $display("FAIL rmid_if got %h want %h", dout, e.flag); end
        a = IE_A; #1;
        n_cmp++;
        if (dout !== 8'h00) begin n_bad++; $display("FAIL rmid_ie got %h want 00", dout); end
        a = NO_A; #1;
        n_cmp++;
        if (dout !== 8'hFF) begin n_bad++; $display("FAIL rmid_unsel got %h want ff", dout); end
        rd = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        int_ack = 1'b0;
        tick();
        exp_q.push_back('{1'b0, 8'h40, 8'hE0});
        e = exp_q.pop_front();
        a = IF_A; rd = 1'b1; #1;
        n_cmp += 3;
        if (int_req !== e.req) begin n_bad++; $display("FAIL rpost_req got %b want %b", int_req, e.req); end
        if (int_vec !== e.vec) begin n_bad++; $display("FAIL rpost_vec got %h want %h", int_vec, e.vec); end
        if (dout !== e.flag) begin n_bad++; $display("FAIL rpost_if got %h want %h", dout, e.flag); end
        rd = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        a       = NO_A;
        din     = 8'h00;
        rd      = 1'b0;
        wr      = 1'b0;
        irq_in  = 5'h00;
        int_ack = 1'b0;
        test_reset();
        test_pulse();
        test_priority();
        test_ack_collision();
        test_write_priority();
        test_held();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 5, number of interrupt channels (legal 1..8).
REQ-002 SHALL have parameter IF_ADDR, default 16'hFF0F, MMIO address of the flag register.
REQ-003 SHALL have parameter IE_ADDR, default 16'hFFFF, MMIO address of the enable register.
REQ-004 SHALL have parameter VEC_BASE, default 8'h40, vector of channel 0.
REQ-005 SHALL have parameter VEC_STRIDE, default 8'h08, vector spacing between channels.
REQ-006 SHALL have port clk, input, 1, system clock, all state on rising edge.
REQ-007 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have ports a (input, 16, CPU address), din (input, 8, CPU write data), dout (output, 8, read data), rd (input, 1, read strobe), wr (input, 1, write strobe).
REQ-009 SHALL have port irq_in, input, NUM_IRQ, peripheral requests.
REQ-010 SHALL have ports int_req (output, 1, enabled interrupt pending), int_vec (output, 8, vector of selected channel), int_ack (input, 1, single-cycle CPU acknowledge).

Function
REQ-011 SHALL hold an NUM_IRQ-bit flag register IF and an NUM_IRQ-bit enable register IE.
REQ-012 SHALL set IF[i] in the cycle after a request event on irq_in[i] (edge or pulse per REQ-026/027).
REQ-013 SHALL on wr with a==IE_ADDR load IE from din[NUM_IRQ-1:0] on the next edge.
REQ-014 SHALL on wr with a==IF_ADDR load IF with din[NUM_IRQ-1:0] OR same-cycle request events; the request event wins.
REQ-015 SHALL drive dout combinationally: a==IF_ADDR gives IF with unimplemented bits 1; a==IE_ADDR gives IE with unimplemented bits 0; else 8'hFF.
REQ-016 SHALL drive int_req = |(IF & IE) combinationally from registered state.
REQ-017 SHALL select the lowest-index set bit of IF & IE as the active channel k (channel 0 highest priority).
REQ-018 SHALL drive int_vec = VEC_BASE + VEC_STRIDE*k, 8-bit wrap-around; VEC_BASE when nothing is pending.
REQ-019 SHALL on int_ack clear IF[k] for the k shown on int_vec in that same cycle.
REQ-020 SHALL ignore int_ack when int_req is 0.
REQ-021 SHALL keep IF[k] set when a request event on channel k coincides with its acknowledge.
REQ-022 SHALL give a CPU write to IF priority over int_ack in the same cycle; the ack is dropped.
REQ-023 SHALL leave IF bits set while IE is clear; they raise int_req once IE is enabled.

Reset
REQ-024 SHALL, while rst is low, force IF=0, IE=0, int_req=0, int_vec=VEC_BASE, dout=8'hFF for unselected addresses, edge history all-ones.
REQ-025 SHALL discard any in-progress acknowledge on reset; no flag survives reset.

Configuration
REQ-026 SHALL, with IRQ_EDGE_DETECT_EN defined, register irq_in each cycle and treat only 0->1 transitions as request events, so a held-high input sets IF once.
REQ-027 SHALL, without IRQ_EDGE_DETECT_EN, treat every cycle irq_in[i]==1 as a request event; peripherals must supply single-cycle pulses.

Verification
REQ-028 Pulse irq_in[2], IE=5'h04 -> next cycle IF=5'h04, int_req=1, int_vec=8'h50; int_ack -> IF=0, int_req=0.
REQ-029 Set IF=5'h1F via wr, IE=5'h1A -> int_vec=8'h48; successive acks give 8'h58, 8'h60, then int_req=0, IF=5'h05.
REQ-030 irq_in[1] pulse in the same cycle as int_ack of channel 1 -> IF[1] remains 1, int_req stays 1.
REQ-031 wr IF_ADDR din=8'h00 with simultaneous irq_in[0] pulse and int_ack -> IF=5'h01; read IF_ADDR -> 8'hE1; read IE_ADDR after IE=5'h1F -> 8'h1F.
REQ-032 With IRQ_EDGE_DETECT_EN, hold irq_in[3] high 10 cycles, ack once -> IF[3]=0 and stays 0; without the macro -> IF[3] re-sets next cycle.
REQ-033 Assert rst low mid-sequence with IF=5'h1F, IE=5'h1F -> immediately int_req=0, int_vec=8'h40, IF=0, IE=0.
